// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - ID/EX input bundle and EX/MEM output bundle of the execute stage
//
// master : upstream/issue side (drives instruction fields, flush, hold; sees busy and EX/MEM outputs)
// slave  : execute_stage (consumes instruction fields, drives busy and EX/MEM outputs)
interface execute_stage_if #(
    parameter int DATA_W     = 24,
    parameter int REG_ADDR_W = 4
);
    // ID/EX side
    logic                  in_valid;
    logic                  flush;
    logic                  hold;
    logic [3:0]            alu_op;
    logic [DATA_W-1:0]     operand_a;
    logic [DATA_W-1:0]     operand_b;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] rd_in;
    logic                  read_enable_in;
    logic                  write_enable_in;
    logic                  mem_to_reg_in;
    logic                  reg_write_in;

    // EX/MEM side
    logic                  busy;
    logic                  out_valid;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     write_data_a;
    logic                  read_enable;
    logic                  write_enable;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd_out;

    modport master (
        output in_valid, flush, hold, alu_op, operand_a, operand_b, store_data, rd_in,
               read_enable_in, write_enable_in, mem_to_reg_in, reg_write_in,
        input  busy, out_valid, alu_result, write_data_a, read_enable, write_enable,
               mem_to_reg, reg_write, rd_out
    );

    modport slave (
        input  in_valid, flush, hold, alu_op, operand_a, operand_b, store_data, rd_in,
               read_enable_in, write_enable_in, mem_to_reg_in, reg_write_in,
        output busy, out_valid, alu_result, write_data_a, read_enable, write_enable,
               mem_to_reg, reg_write, rd_out
    );
endinterface

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: single-cycle ALU plus iterative shift-add MUL into EX/MEM
//
// Ports:
//   clk   : stage clock
//   reset : asynchronous, active-low; clears all state and outputs
//   ex    : execute_stage_if.slave - instruction fields, flush/hold in; busy and EX/MEM registers out
module execute_stage #(
    parameter int DATA_W     = 24,
    parameter int REG_ADDR_W = 4,
    parameter int MUL_CYCLES = 24
) (
    input  logic              clk,
    input  logic              reset,
    execute_stage_if.slave    ex
);
    localparam int         CNT_W  = $clog2(MUL_CYCLES + 1);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_PSB = 4'd9;

    typedef enum logic {IDLE, MUL_RUN} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]      cnt;
    logic [DATA_W-1:0]     acc;
    logic [DATA_W-1:0]     mcand;
    logic [DATA_W-1:0]     mplier;
    logic [DATA_W-1:0]     mul_store;
    logic [REG_ADDR_W-1:0] mul_rd;
    logic [3:0]            mul_ctl;

    logic                  out_valid_q;
    logic [DATA_W-1:0]     alu_result_q;
    logic [DATA_W-1:0]     write_data_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [3:0]            ctl_q;          // {read_enable, write_enable, mem_to_reg, reg_write}

    logic [DATA_W-1:0]     alu_value;
    logic [4:0]            shamt;
    logic                  shift_over;
    logic [DATA_W-1:0]     acc_step;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  mul_done;
    logic [3:0]            ctl_in;

    assign shamt      = ex.operand_b[4:0];
    assign shift_over = ({27'd0, shamt} >= 32'(DATA_W));
    assign ctl_in     = {ex.read_enable_in, ex.write_enable_in, ex.mem_to_reg_in, ex.reg_write_in};

    // One shift-add iteration: the final iteration's sum is written straight to alu_result.
    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign cnt_inc  = cnt + 1'b1;
    assign mul_done = (state == MUL_RUN) && (cnt_inc == CNT_W'(MUL_CYCLES));

    always_comb begin
        alu_value = '0;
        case (ex.alu_op)
            OP_ADD: alu_value = ex.operand_a + ex.operand_b;
            OP_SUB: alu_value = ex.operand_a - ex.operand_b;
            OP_AND: alu_value = ex.operand_a & ex.operand_b;
            OP_OR:  alu_value = ex.operand_a | ex.operand_b;
            OP_XOR: alu_value = ex.operand_a ^ ex.operand_b;
            OP_SLL: alu_value = shift_over ? '0 : (ex.operand_a << shamt);
            OP_SRL: alu_value = shift_over ? '0 : (ex.operand_a >> shamt);
            OP_SLT: alu_value = {{(DATA_W-1){1'b0}}, ($signed(ex.operand_a) < $signed(ex.operand_b))};
            OP_PSB: alu_value = ex.operand_b;
            default: alu_value = '0;   // MUL result comes from the iterative path; 10-15 yield 0
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (ex.flush) begin
            state_next = IDLE;
        end else if (!ex.hold) begin
            case (state)
                IDLE:    if (ex.in_valid && ex.alu_op == OP_MUL) state_next = MUL_RUN;
                MUL_RUN: if (mul_done) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            mul_store    <= '0;
            mul_rd       <= '0;
            mul_ctl      <= '0;
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
            ctl_q        <= '0;
        end else if (ex.flush) begin
            // Kill: data outputs keep their last values, only validity and controls drop.
            cnt         <= '0;
            out_valid_q <= 1'b0;
            ctl_q       <= '0;
        end else if (!ex.hold) begin
            if (state == IDLE) begin
                if (ex.in_valid && ex.alu_op == OP_MUL) begin
                    mcand       <= ex.operand_a;
                    mplier      <= ex.operand_b;
                    mul_store   <= ex.store_data;
                    mul_rd      <= ex.rd_in;
                    mul_ctl     <= ctl_in;
                    acc         <= '0;
                    cnt         <= '0;
                    out_valid_q <= 1'b0;
                    ctl_q       <= '0;
                end else if (ex.in_valid) begin
                    out_valid_q  <= 1'b1;
                    alu_result_q <= alu_value;
                    write_data_q <= ex.store_data;
                    rd_q         <= ex.rd_in;
                    ctl_q        <= ctl_in;
                end else begin
                    out_valid_q <= 1'b0;
                    ctl_q       <= '0;
                end
            end else begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt_inc;
                if (mul_done) begin
                    out_valid_q  <= 1'b1;
                    alu_result_q <= acc_step;
                    write_data_q <= mul_store;
                    rd_q         <= mul_rd;
                    ctl_q        <= mul_ctl;
                end
            end
        end
    end

    assign ex.busy         = (state == MUL_RUN);
    assign ex.out_valid    = out_valid_q;
    assign ex.alu_result   = alu_result_q;
    assign ex.write_data_a = write_data_q;
    assign ex.rd_out       = rd_q;
    assign ex.read_enable  = ctl_q[3];
    assign ex.write_enable = ctl_q[2];
    assign ex.mem_to_reg   = ctl_q[1];
    assign ex.reg_write    = ctl_q[0];
endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage
module tb_execute_stage;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    execute_stage_if #(.DATA_W(24), .REG_ADDR_W(4)) ex_if ();

    execute_stage #(.DATA_W(24), .REG_ADDR_W(4), .MUL_CYCLES(24)) dut (
        .clk   (clk),
        .reset (reset),
        .ex    (ex_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] sd;
        logic [3:0]  rd;
        logic [3:0]  ctl;   // {re, we, m2r, rw}
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] sd, input logic [3:0] rd, input logic [3:0] ctl);
        ex_if.in_valid        = v;
        ex_if.alu_op          = op;
        ex_if.operand_a       = a;
        ex_if.operand_b       = b;
        ex_if.store_data      = sd;
        ex_if.rd_in           = rd;
        ex_if.read_enable_in  = ctl[3];
        ex_if.write_enable_in = ctl[2];
        ex_if.mem_to_reg_in   = ctl[1];
        ex_if.reg_write_in    = ctl[0];
    endtask

    task automatic check_out(input string tag, input logic ov, input logic bz, input logic [23:0] res,
                             input logic [23:0] wd, input logic [3:0] rd, input logic [3:0] ctl);
        chk({tag, ".out_valid"},    32'(ex_if.out_valid), 32'(ov));
        chk({tag, ".busy"},         32'(ex_if.busy), 32'(bz));
        chk({tag, ".alu_result"},   32'(ex_if.alu_result), 32'(res));
        chk({tag, ".write_data_a"}, 32'(ex_if.write_data_a), 32'(wd));
        chk({tag, ".rd_out"},       32'(ex_if.rd_out), 32'(rd));
        chk({tag, ".controls"},     32'({ex_if.read_enable, ex_if.write_enable, ex_if.mem_to_reg, ex_if.reg_write}),
            32'(ctl));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts a MUL on the next edge (edge N) and returns with inputs idled, 1 time unit after edge N.
    task automatic start_mul(input logic [23:0] a, input logic [23:0] b, input logic [23:0] sd,
                             input logic [3:0] rd, input logic [3:0] ctl);
        @(negedge clk);
        drive(1'b1, 4'd8, a, b, sd, rd, ctl);
        tick();
        drive(1'b0, 4'd0, 24'h0, 24'h0, 24'h0, 4'd0, 4'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        ex_if.flush = 1'b0;
        ex_if.hold  = 1'b0;
        drive(1'b0, 4'd0, 24'h0, 24'h0, 24'h0, 4'd0, 4'd0);

        vecs[0]  = '{4'd0,  24'hFFFFFF, 24'h000001, 24'h000000, 4'd1,  4'b0001, 24'h000000};
        vecs[1]  = '{4'd0,  24'd89999,  24'd1,      24'h000000, 4'd3,  4'b1010, 24'd90000};
        vecs[2]  = '{4'd1,  24'h000000, 24'h000001, 24'h111111, 4'd2,  4'b0001, 24'hFFFFFF};
        vecs[3]  = '{4'd1,  24'h000005, 24'h000007, 24'h000000, 4'd4,  4'b0001, 24'hFFFFFE};
        vecs[4]  = '{4'd2,  24'hF0F0F0, 24'h0FF00F, 24'h000000, 4'd5,  4'b0001, 24'h00F000};
        vecs[5]  = '{4'd3,  24'h123000, 24'h000456, 24'h000000, 4'd6,  4'b0001, 24'h123456};
        vecs[6]  = '{4'd4,  24'hFFFF00, 24'h0F0F0F, 24'h000000, 4'd7,  4'b0001, 24'hF0F00F};
        vecs[7]  = '{4'd5,  24'h000001, 24'd23,     24'h000000, 4'd8,  4'b0001, 24'h800000};
        vecs[8]  = '{4'd5,  24'h000001, 24'd24,     24'h000000, 4'd9,  4'b0001, 24'h000000};
        vecs[9]  = '{4'd5,  24'h000003, 24'h000020, 24'h000000, 4'd10, 4'b0001, 24'h000003};
        vecs[10] = '{4'd6,  24'h800000, 24'd4,      24'h000000, 4'd11, 4'b0001, 24'h080000};
        vecs[11] = '{4'd6,  24'hFFFFFF, 24'd31,     24'h000000, 4'd12, 4'b0001, 24'h000000};
        vecs[12] = '{4'd7,  24'h000001, 24'h800000, 24'h000000, 4'd13, 4'b0001, 24'h000000};
        vecs[13] = '{4'd7,  24'hFFFFFF, 24'h000000, 24'h000000, 4'd14, 4'b0001, 24'h000001};
        vecs[14] = '{4'd9,  24'h111111, 24'h654321, 24'h0000AA, 4'd15, 4'b0100, 24'h654321};
        vecs[15] = '{4'd13, 24'h123456, 24'h654321, 24'h000000, 4'd1,  4'b0001, 24'h000000};

        // Reset state, held across a clock edge
        tick();
        tick();
        check_out("reset", 1'b0, 1'b0, 24'h0, 24'h0, 4'd0, 4'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single-cycle ops
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sd, vecs[i].rd, vecs[i].ctl);
            tick();
            check_out($sformatf("vec%0d", i), 1'b1, 1'b0, vecs[i].exp, vecs[i].sd, vecs[i].rd, vecs[i].ctl);
        end

        // Hold freezes a completed result even with a new valid instruction present
        @(negedge clk);
        ex_if.hold = 1'b1;
        drive(1'b1, 4'd0, 24'd2, 24'd2, 24'h5, 4'd2, 4'b1111);
        tick();
        check_out("hold_idle", 1'b1, 1'b0, 24'h0, 24'h0, 4'd1, 4'b0001);
        @(negedge clk);
        ex_if.hold = 1'b0;

        // Bubble: validity/controls drop, data retained
        drive(1'b0, 4'd0, 24'd7, 24'd7, 24'h9, 4'd9, 4'b1111);
        tick();
        check_out("bubble", 1'b0, 1'b0, 24'h0, 24'h0, 4'd1, 4'b0000);

        // MUL 300 x 300, per-cycle busy/out_valid
        start_mul(24'd300, 24'd300, 24'h00BEEF, 4'd7, 4'b0001);
        for (int i = 1; i <= 23; i++) begin
            tick();
            chk($sformatf("mul_busy_%0d", i), 32'(ex_if.busy), 32'd1);
            chk($sformatf("mul_ov_%0d", i), 32'(ex_if.out_valid), 32'd0);
        end
        tick();
        check_out("mul300", 1'b1, 1'b0, 24'd90000, 24'h00BEEF, 4'd7, 4'b0001);
        tick();
        check_out("mul_after", 1'b0, 1'b0, 24'd90000, 24'h00BEEF, 4'd7, 4'b0000);

        // Wrap: (2^24-1)^2 mod 2^24 = 1
        start_mul(24'hFFFFFF, 24'hFFFFFF, 24'h000000, 4'd6, 4'b0001);
        repeat (24) tick();
        check_out("mul_ff", 1'b1, 1'b0, 24'h000001, 24'h000000, 4'd6, 4'b0001);

        // MUL with 5-cycle hold after edge N+10: result at N+29
        start_mul(24'd300, 24'd300, 24'h000000, 4'd5, 4'b0001);
        repeat (10) tick();
        ex_if.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("mul_hold_%0d", i), 1'b0, 1'b1, 24'h000001, 24'h000000, 4'd6, 4'b0000);
        end
        ex_if.hold = 1'b0;
        repeat (13) tick();
        chk("mul_hold_busy_n28", 32'(ex_if.busy), 32'd1);
        chk("mul_hold_ov_n28", 32'(ex_if.out_valid), 32'd0);
        tick();
        check_out("mul_hold_done", 1'b1, 1'b0, 24'd90000, 24'h000000, 4'd5, 4'b0001);

        // Flush on edge N+10 of a MUL; the ADD present on the flush edge is not taken
        start_mul(24'd300, 24'd300, 24'h000000, 4'd4, 4'b0001);
        repeat (9) tick();
        ex_if.flush = 1'b1;
        drive(1'b1, 4'd0, 24'd2, 24'd3, 24'h000000, 4'd8, 4'b0001);
        tick();
        check_out("flush", 1'b0, 1'b0, 24'd90000, 24'h000000, 4'd5, 4'b0000);
        ex_if.flush = 1'b0;
        tick();
        check_out("add_after_flush", 1'b1, 1'b0, 24'd5, 24'h000000, 4'd8, 4'b0001);
        tick();
        check_out("no_late_mul", 1'b1, 1'b0, 24'd5, 24'h000000, 4'd8, 4'b0001);

        // Store via SLT, then asynchronous reset mid-cycle
        @(negedge clk);
        drive(1'b1, 4'd7, 24'h800000, 24'h000001, 24'hABCDEF, 4'd0, 4'b0100);
        tick();
        check_out("store_slt", 1'b1, 1'b0, 24'h000001, 24'hABCDEF, 4'd0, 4'b0100);
        drive(1'b0, 4'd0, 24'h0, 24'h0, 24'h0, 4'd0, 4'd0);
        #2;
        reset = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 1'b0, 24'h0, 24'h0, 4'd0, 4'd0);
        @(negedge clk);
        reset = 1'b1;

        // Reset mid-MUL: no partial result afterwards
        start_mul(24'd300, 24'd300, 24'h000123, 4'd3, 4'b0001);
        repeat (5) tick();
        #2;
        reset = 1'b0;
        #1;
        check_out("reset_mid_mul", 1'b0, 1'b0, 24'h0, 24'h0, 4'd0, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (25) tick();
        check_out("after_reset_mul", 1'b0, 1'b0, 24'h0, 24'h0, 4'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
